addr_seq_gen: RTL and testbench

- Parametrised successor to the CPU address buffer.
- Sequences the multi-cycle effective-address calculation for all 6502-style addressing modes: zero page, zero page indexed, stack, PC, absolute and absolute indexed.
- Collects operand bytes from the data bus and emits a validated effective address with a page-cross flag.
- Sits between the instruction decoder (start/mode), the register file (X, Y, SP) and the memory address pins.

---
 rtl/addr_seq_gen_pkg.sv | 49 ++++
 rtl/addr_seq_gen_idx_adder.sv | 34 +++
 rtl/addr_seq_gen.sv | 198 +++++++++++++++++++
 tb/tb_addr_seq_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/addr_seq_gen_pkg.sv
// Shared types for the effective-address sequencer: mode and state encodings,
// default page bytes and a small addressing-mode classifier.
package addr_seq_gen_pkg;

    localparam logic [7:0] ZP_PAGE_DEF    = 8'h00;
    localparam logic [7:0] STACK_PAGE_DEF = 8'h01;

    typedef enum logic [2:0] {
        MODE_ZERO    = 3'd0,
        MODE_ZERO_X  = 3'd1,
        MODE_ZERO_Y  = 3'd2,
        MODE_STACK   = 3'd3,
        MODE_PC      = 3'd4,
        MODE_ABSOL   = 3'd5,
        MODE_ABSOL_X = 3'd6,
        MODE_ABSOL_Y = 3'd7
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OP_LO = 3'd1,
        ST_OP_HI = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic is_zero;
        logic is_abs;
        logic uses_x;
        logic uses_y;
    } mode_class_t;

    function automatic mode_class_t mode_class(input mode_e m);
        mode_class_t c;
        c = '{is_zero: 1'b0, is_abs: 1'b0, uses_x: 1'b0, uses_y: 1'b0};
        case (m)
            MODE_ZERO:    c.is_zero = 1'b1;
            MODE_ZERO_X:  begin c.is_zero = 1'b1; c.uses_x = 1'b1; end
            MODE_ZERO_Y:  begin c.is_zero = 1'b1; c.uses_y = 1'b1; end
            MODE_ABSOL:   c.is_abs = 1'b1;
            MODE_ABSOL_X: begin c.is_abs = 1'b1; c.uses_x = 1'b1; end
            MODE_ABSOL_Y: begin c.is_abs = 1'b1; c.uses_y = 1'b1; end
            default:      c = '{is_zero: 1'b0, is_abs: 1'b0, uses_x: 1'b0, uses_y: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/addr_seq_gen_idx_adder.sv
// Index adder for effective addresses: zero-page modes wrap inside the page,
// absolute modes carry into the high byte (uncarried form kept for dummy reads).
module addr_seq_gen_idx_adder #(
    parameter int DW = 8,
    parameter int AW = 16
) (
    input  logic [DW-1:0] lo,
    input  logic [DW-1:0] hi,
    input  logic [DW-1:0] idx,
    input  logic          zp_wrap,
    output logic [AW-1:0] eff,
    output logic          carry,
    output logic [AW-1:0] uncarried_addr
);

    logic [DW:0]   sum_s;
    logic [DW-1:0] hi_inc_s;

    assign sum_s          = {1'b0, lo} + {1'b0, idx};
    assign hi_inc_s       = hi + {{(DW-1){1'b0}}, sum_s[DW]};
    assign uncarried_addr = {hi, sum_s[DW-1:0]};

    // Select wrapped or carried result
    always_comb begin
        if (zp_wrap) begin
            eff   = {hi, sum_s[DW-1:0]};
            carry = 1'b0;
        end else begin
            eff   = {hi_inc_s, sum_s[DW-1:0]};
            carry = sum_s[DW];
        end
    end

endmodule

// File: rtl/addr_seq_gen.sv
// Effective-address sequencer for 6502-style addressing modes.
// Define ADDR_PAGE_FIX_EN to insert a dummy (uncorrected) read cycle on indexed page crossings.
module addr_seq_gen
    import addr_seq_gen_pkg::*;
#(
    parameter int            DW         = 8,
    parameter int            AW         = 16,
    parameter logic [DW-1:0] ZP_PAGE    = DW'(ZP_PAGE_DEF),
    parameter logic [DW-1:0] STACK_PAGE = DW'(STACK_PAGE_DEF)
) (
    input  logic          clk_1,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic          byte_vld,
    input  logic [DW-1:0] data_bus,
    input  logic [DW-1:0] data_x,
    input  logic [DW-1:0] data_y,
    input  logic [DW-1:0] data_sp,
    input  logic [AW-1:0] pc_in,
    output logic [AW-1:0] address,
    output logic          addr_valid,
    output logic          dummy,
    output logic          page_cross,
    output logic          busy
);

    state_e        state_r, state_nxt_s;
    mode_e         mode_r, mode_in_s;
    mode_class_t   mc_s;
    logic [DW-1:0] lo_r;
    logic [AW-1:0] eff_r, unc_r;
    logic          carry_r;
    logic [DW-1:0] idx_s, add_lo_s, add_hi_s;
    logic          add_zp_s, add_carry_s;
    logic [AW-1:0] add_eff_s, add_unc_s;

    assign mode_in_s = mode_e'(mode);
    assign mc_s      = mode_class(mode_r);

    // Adder operand selection: zero-page add in OP_LO, absolute add in OP_HI
    always_comb begin
        if (mc_s.uses_x) begin
            idx_s = data_x;
        end else if (mc_s.uses_y) begin
            idx_s = data_y;
        end else begin
            idx_s = {DW{1'b0}};
        end
        if (state_r == ST_OP_LO) begin
            add_lo_s = data_bus;
            add_hi_s = ZP_PAGE;
            add_zp_s = 1'b1;
        end else begin
            add_lo_s = lo_r;
            add_hi_s = data_bus;
            add_zp_s = 1'b0;
        end
    end

    addr_seq_gen_idx_adder #(.DW(DW), .AW(AW)) u_idx_adder (
        .lo             (add_lo_s),
        .hi             (add_hi_s),
        .idx            (idx_s),
        .zp_wrap        (add_zp_s),
        .eff            (add_eff_s),
        .carry          (add_carry_s),
        .uncarried_addr (add_unc_s)
    );

    // State register
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (mode_in_s == MODE_STACK || mode_in_s == MODE_PC) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_OP_LO;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OP_LO: begin
                if (byte_vld) begin
                    if (mc_s.is_zero) begin
                        state_nxt_s = ST_DONE;
                    end else if (mc_s.is_abs) begin
                        state_nxt_s = ST_OP_HI;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_OP_LO;
                end
            end
            ST_OP_HI: begin
                if (byte_vld) begin
`ifdef ADDR_PAGE_FIX_EN
                    if (add_carry_s) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
`else
                    state_nxt_s = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_OP_HI;
                end
            end
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand and result registers; SP/PC captured with the accepted start
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            mode_r  <= MODE_ZERO;
            lo_r    <= {DW{1'b0}};
            eff_r   <= {AW{1'b0}};
            unc_r   <= {AW{1'b0}};
            carry_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r  <= mode_in_s;
                        carry_r <= 1'b0;
                        if (mode_in_s == MODE_STACK) begin
                            eff_r <= {STACK_PAGE, data_sp};
                        end else if (mode_in_s == MODE_PC) begin
                            eff_r <= pc_in;
                        end
                    end
                end
                ST_OP_LO: begin
                    if (byte_vld) begin
                        lo_r    <= data_bus;
                        eff_r   <= add_eff_s;
                        carry_r <= add_carry_s;
                    end
                end
                ST_OP_HI: begin
                    if (byte_vld) begin
                        eff_r   <= add_eff_s;
                        carry_r <= add_carry_s;
                        unc_r   <= add_unc_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the current state
    always_comb begin
        address    = pc_in;
        addr_valid = 1'b0;
        dummy      = 1'b0;
        page_cross = 1'b0;
        busy       = 1'b1;
        case (state_r)
            ST_IDLE:  busy = 1'b0;
            ST_OP_LO: busy = 1'b1;
            ST_OP_HI: busy = 1'b1;
            ST_FIX: begin
                address = unc_r;
`ifdef ADDR_PAGE_FIX_EN
                dummy   = 1'b1;
`else
                dummy   = 1'b0;
`endif
            end
            ST_DONE: begin
                address    = eff_r;
                addr_valid = 1'b1;
                page_cross = carry_r;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_addr_seq_gen.sv
// Self-checking bench for addr_seq_gen: expected addresses are queued at start
// and popped by a monitor whenever the DUT presents a valid or dummy address.
module tb_addr_seq_gen;

    logic        clk_1 = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        byte_vld = 1'b0;
    logic [7:0]  data_bus = 8'h00;
    logic [7:0]  data_x = 8'h00;
    logic [7:0]  data_y = 8'h00;
    logic [7:0]  data_sp = 8'h00;
    logic [15:0] pc_in = 16'hC000;
    logic [15:0] address;
    logic        addr_valid, dummy, page_cross, busy;

    int n_chk = 0;
    int n_err = 0;
    int n_valid = 0;

    typedef struct {
        logic        is_dummy;
        logic [15:0] addr;
        logic        pc;
    } exp_t;
    exp_t sb_q[$];

    addr_seq_gen dut (
        .clk_1(clk_1), .rst(rst), .start(start), .mode(mode), .byte_vld(byte_vld),
        .data_bus(data_bus), .data_x(data_x), .data_y(data_y), .data_sp(data_sp),
        .pc_in(pc_in), .address(address), .addr_valid(addr_valid), .dummy(dummy),
        .page_cross(page_cross), .busy(busy)
    );

    always #5 clk_1 = ~clk_1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk_1) begin
        exp_t e;
        if (rst && (addr_valid || dummy)) begin
            if (addr_valid) n_valid++;
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", 32'({addr_valid, dummy}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_kind", 32'({addr_valid, dummy}), e.is_dummy ? 32'd1 : 32'd2);
                check_eq("sb_addr", 32'(address), 32'(e.addr));
                if (addr_valid) check_eq("sb_pcross", 32'(page_cross), 32'(e.pc));
            end
        end
    end

    task automatic push_expect(input logic [2:0] m, input logic [7:0] lo, input logic [7:0] hi,
                               input logic [7:0] x, input logic [7:0] y, input logic [7:0] sp,
                               input logic [15:0] pc);
        exp_t e;
        logic [7:0] idx;
        logic [7:0] sum8;
        logic [8:0] s;
        idx = (m == 3'd1 || m == 3'd6) ? x : ((m == 3'd2 || m == 3'd7) ? y : 8'h00);
        sum8 = lo + idx;
        s = {1'b0, lo} + {1'b0, idx};
        e.is_dummy = 1'b0;
        e.pc = 1'b0;
        case (m)
            3'd0, 3'd1, 3'd2: e.addr = {8'h00, sum8};
            3'd3: e.addr = {8'h01, sp};
            3'd4: e.addr = pc;
            default: begin
`ifdef ADDR_PAGE_FIX_EN
                if (s[8]) sb_q.push_back('{is_dummy: 1'b1, addr: {hi, s[7:0]}, pc: 1'b0});
`endif
                e.addr = {hi + {7'd0, s[8]}, s[7:0]};
                e.pc = s[8];
            end
        endcase
        sb_q.push_back(e);
    endtask

    task automatic run_seq(input logic [2:0] m, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [7:0] x, input logic [7:0] y, input logic [7:0] sp,
                           input logic [15:0] pc, input int gap, input bit junk, input bit spam);
        logic [15:0] pc_after;
        pc_after = pc ^ 16'h5A5A;
        data_x = x; data_y = y; data_sp = sp; pc_in = pc; mode = m;
        start = 1'b1; byte_vld = junk; data_bus = 8'hA5;
        push_expect(m, lo, hi, x, y, sp, pc);
        tick();
        start = spam; mode = 3'd3; byte_vld = 1'b0;
        data_sp = ~sp; pc_in = pc_after;
        if (m != 3'd3 && m != 3'd4) begin
            repeat (gap) tick();
            byte_vld = 1'b1; data_bus = lo;
            tick();
            byte_vld = 1'b0; data_bus = 8'h00;
            if (m >= 3'd5) begin
                repeat (gap) tick();
                byte_vld = 1'b1; data_bus = hi;
                tick();
                byte_vld = 1'b0; data_bus = 8'h00;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (!busy) break;
            tick();
        end
        start = 1'b0;
        check_eq("done_timeout", 32'(busy), 32'd0);
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        check_eq("idle_addr", 32'(address), 32'(pc_after));
        if (spam) begin
            tick();
            check_eq("spam_ignored", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nv0;
        // Reset state
        #12;
        check_eq("rst_addr", 32'(address), 32'h0000C000);
        check_eq("rst_valid", 32'(addr_valid), 32'd0);
        check_eq("rst_dummy", 32'(dummy), 32'd0);
        check_eq("rst_pcross", 32'(page_cross), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk_1);
        rst = 1'b1;
        tick();

        run_seq(3'd1, 8'hF0, 8'h00, 8'h20, 8'h00, 8'h00, 16'hC000, 0, 1'b0, 1'b0);
        run_seq(3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 16'hC010, 0, 1'b0, 1'b0);
        run_seq(3'd7, 8'h80, 8'h12, 8'h00, 8'h10, 8'h00, 16'hC020, 3, 1'b0, 1'b0);
        run_seq(3'd6, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 16'hC030, 0, 1'b0, 1'b0);
        run_seq(3'd4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'hBEEF, 1, 1'b1, 1'b0);

        // Reset pulled in OP_HI aborts the sequence
        nv0 = n_valid;
        pc_in = 16'hC000; mode = 3'd5; start = 1'b1;
        tick();
        start = 1'b0; byte_vld = 1'b1; data_bus = 8'h34;
        tick();
        byte_vld = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_addr", 32'(address), 32'h0000C000);
        check_eq("abort_valid", 32'(addr_valid), 32'd0);
        tick();
        @(negedge clk_1);
        rst = 1'b1;
        repeat (3) tick();
        check_eq("abort_no_valid", 32'(n_valid - nv0), 32'd0);
        run_seq(3'd0, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 16'hC000, 0, 1'b0, 1'b0);

        // Start held high while busy yields a single result
        nv0 = n_valid;
        run_seq(3'd5, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 16'hC040, 1, 1'b0, 1'b1);
        check_eq("spam_one_valid", 32'(n_valid - nv0), 32'd1);

        for (int k = 0; k < 24; k++) begin
            run_seq(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 16'($urandom), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
